// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU tile scheduler and its tile counter.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package tpu_pkg;

    localparam int TILE      = 4;   // systolic array edge
    localparam int ADDR_BITS = 16;  // global buffer index width
    localparam int DIM_W     = 8;   // K/M/N width
    localparam int TCNT_W    = 6;   // tile index width (0..63)

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        WB,
        DONE
    } state_t;

    // Index of the last tile along a dimension: ceil(dim/TILE)-1 == (dim-1)/TILE.
    // Only meaningful for dim >= 1; zero dimensions are rejected before this is used.
    function automatic logic [TCNT_W-1:0] last_tile_idx(input logic [DIM_W-1:0] dim);
        return TCNT_W'((dim - 1'b1) >> $clog2(TILE));
    endfunction

endpackage

// File: rtl/tpu_tile_counter.sv
// 2-D tile walker: mt is the inner index, nt the outer; both wrap to 0 after the last tile.
// Latency: counters move on the edge where advance is high; last_tile decodes the current value.
// Backpressure: none; advance is honoured every cycle it is asserted, clear has priority.
//
// Ports: clk, rst_n (async active-low), clear (restart at tile 0,0), advance (step one tile),
//        mt_last/nt_last (last valid index per axis), mt/nt (current tile), last_tile.
module tpu_tile_counter
    import tpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [TCNT_W-1:0] mt_last,
    input  logic [TCNT_W-1:0] nt_last,
    output logic [TCNT_W-1:0] mt,
    output logic [TCNT_W-1:0] nt,
    output logic              last_tile
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt <= '0;
            nt <= '0;
        end else if (clear) begin
            mt <= '0;
            nt <= '0;
        end else if (advance) begin
            if (mt == mt_last) begin
                mt <= '0;
                nt <= (nt == nt_last) ? '0 : nt + TCNT_W'(1);
            end else begin
                mt <= mt + TCNT_W'(1);
            end
        end
    end

    assign last_tile = (mt == mt_last) && (nt == nt_last);

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Walks C = A*B over the 4x4 systolic array tile by tile: start pulse, wait for sa_done, 4-row writeback.
// Latency: accept -> sa_start next cycle; sa_done -> first writeback row next cycle; done 1 cycle after last row.
// Backpressure: in_valid ignored while busy; the array throttles via sa_done; writeback never stalls.
//
// Ports: clk, rst_n; job request in_valid with K/M/N; status busy/done/err;
//        array side sa_start, a_base, b_base, k_len, sa_done; writeback wb_row, C_wr_en, C_index;
//        debug tile_m/tile_n (current tile coordinates).
module tpu_tile_scheduler #(
    parameter int TILE      = 4,
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           K,
    input  logic [7:0]           M,
    input  logic [7:0]           N,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 sa_start,
    output logic [ADDR_BITS-1:0] a_base,
    output logic [ADDR_BITS-1:0] b_base,
    output logic [7:0]           k_len,
    input  logic                 sa_done,
    output logic [1:0]           wb_row,
    output logic                 C_wr_en,
    output logic [ADDR_BITS-1:0] C_index,
    output logic [5:0]           tile_m,
    output logic [5:0]           tile_n
);
    import tpu_pkg::*;

    localparam logic [1:0] LAST_ROW = 2'(TILE - 1);

    state_t            state;
    logic [DIM_W-1:0]  k_lat;
    logic [DIM_W-1:0]  m_lat;
    logic [TCNT_W-1:0] mt_last;
    logic [TCNT_W-1:0] nt_last;
    logic [1:0]        row;
    logic [TCNT_W-1:0] mt;
    logic [TCNT_W-1:0] nt;
    logic              last_tile;
    logic              dims_ok;
    logic              accept;
    logic              advance;
    logic [ADDR_BITS-1:0] mpad;
    logic [ADDR_BITS-1:0] row_m;

    assign dims_ok = (K != '0) && (M != '0) && (N != '0);
    assign accept  = (state == IDLE) && in_valid && dims_ok;
    // Tile pointer steps on the final writeback row so the next START already sees the new tile.
    assign advance = (state == WB) && (row == LAST_ROW);

    tpu_tile_counter u_tile_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .advance   (advance),
        .mt_last   (mt_last),
        .nt_last   (nt_last),
        .mt        (mt),
        .nt        (nt),
        .last_tile (last_tile)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k_lat   <= '0;
            m_lat   <= '0;
            mt_last <= '0;
            nt_last <= '0;
            row     <= '0;
            err     <= 1'b0;
        end else begin
            err <= (state == IDLE) && in_valid && !dims_ok;
            case (state)
                IDLE: begin
                    if (accept) begin
                        k_lat   <= K;
                        m_lat   <= M;
                        mt_last <= last_tile_idx(M);
                        nt_last <= last_tile_idx(N);
                        row     <= '0;
                        state   <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (sa_done) begin
                        state <= WB;
                    end
                end
                WB: begin
                    row <= row + 2'd1;
                    if (row == LAST_ROW) begin
                        row   <= '0;
                        state <= last_tile ? DONE : START;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; nothing here sees an input combinationally.
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign sa_start = (state == START);
    assign k_len    = k_lat;
    assign wb_row   = row;
    assign tile_m   = mt;
    assign tile_n   = nt;

    assign a_base = ADDR_BITS'(mt) * ADDR_BITS'(k_lat);
    assign b_base = ADDR_BITS'(nt) * ADDR_BITS'(k_lat);

    // C is laid out column-tile major with the row count padded up to a whole tile.
    assign mpad    = (ADDR_BITS'(mt_last) + ADDR_BITS'(1)) * ADDR_BITS'(TILE);
    assign row_m   = ADDR_BITS'(mt) * ADDR_BITS'(TILE) + ADDR_BITS'(row);
    assign C_index = (state == WB) ? ADDR_BITS'(nt) * mpad + row_m : '0;
    // Padding rows beyond M still consume a cycle but are not written.
    assign C_wr_en = (state == WB) && (row_m < ADDR_BITS'(m_lat));

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
module tb_tpu_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  K, M, N;
    logic        busy, done, err, sa_start;
    logic [15:0] a_base, b_base;
    logic [7:0]  k_len;
    logic        sa_done;
    logic [1:0]  wb_row;
    logic        C_wr_en;
    logic [15:0] C_index;
    logic [5:0]  tile_m, tile_n;

    always #5 clk = ~clk;

    tpu_tile_scheduler #(.TILE(4), .ADDR_BITS(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .K        (K),
        .M        (M),
        .N        (N),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .sa_start (sa_start),
        .a_base   (a_base),
        .b_base   (b_base),
        .k_len    (k_len),
        .sa_done  (sa_done),
        .wb_row   (wb_row),
        .C_wr_en  (C_wr_en),
        .C_index  (C_index),
        .tile_m   (tile_m),
        .tile_n   (tile_n)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [5:0]  tm;
        logic [5:0]  tn;
    } tile_t;

    typedef struct {
        logic [15:0] idx;
        logic [1:0]  row;
    } wr_t;

    tile_t exp_tile[$];
    wr_t   exp_wr[$];
    tile_t et;
    wr_t   ew;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cnt_start, cnt_wr, cnt_done, cnt_err;
    int last_wr_cyc, done_cyc;

    // Scoreboard monitor: every tile start and every write strobe pops the next expectation.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (sa_start) begin
                cnt_start++;
                n_cmp++;
                if (exp_tile.size() == 0) begin
                    n_bad++;
                    $display("FAIL tile_start: unexpected sa_start a_base=%0d b_base=%0d", a_base, b_base);
                end else begin
                    et = exp_tile.pop_front();
                    if ({a_base, b_base, tile_m, tile_n} !== {et.a, et.b, et.tm, et.tn}) begin
                        n_bad++;
                        $display("FAIL tile_start: got a=%0d b=%0d m=%0d n=%0d want a=%0d b=%0d m=%0d n=%0d",
                                 a_base, b_base, tile_m, tile_n, et.a, et.b, et.tm, et.tn);
                    end
                end
            end
            if (C_wr_en) begin
                cnt_wr++;
                last_wr_cyc = cyc;
                n_cmp++;
                if (exp_wr.size() == 0) begin
                    n_bad++;
                    $display("FAIL c_write: unexpected write C_index=%0d", C_index);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({C_index, wb_row} !== {ew.idx, ew.row}) begin
                        n_bad++;
                        $display("FAIL c_write: got idx=%0d row=%0d want idx=%0d row=%0d",
                                 C_index, wb_row, ew.idx, ew.row);
                    end
                end
            end
            if (done) begin
                cnt_done++;
                done_cyc = cyc;
            end
            if (err) cnt_err++;
        end
    end

    // Reference model: tile order mt inner / nt outer, C rows padded to whole tiles.
    task automatic push_exp(input int k, input int m, input int n);
        int mtc = (m + 3) / 4;
        int ntc = (n + 3) / 4;
        for (int t_n = 0; t_n < ntc; t_n++) begin
            for (int t_m = 0; t_m < mtc; t_m++) begin
                exp_tile.push_back('{a: 16'(t_m * k), b: 16'(t_n * k), tm: 6'(t_m), tn: 6'(t_n)});
                for (int r = 0; r < 4; r++) begin
                    if (t_m * 4 + r < m)
                        exp_wr.push_back('{idx: 16'(t_n * mtc * 4 + t_m * 4 + r), row: 2'(r)});
                end
            end
        end
    endtask

    task automatic clear_counts();
        cnt_start = 0; cnt_wr = 0; cnt_done = 0; cnt_err = 0;
        last_wr_cyc = -1; done_cyc = -100;
    endtask

    // Plays the array: answers each sa_start with a one-cycle sa_done after dly WAIT cycles.
    // Returns at the negedge where done is visible, or with finished=0 on budget expiry.
    task automatic drive_job(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n,
                             input int dly, input bit poke, output bit finished);
        int cd;
        bit poked;
        finished = 0; cd = -1; poked = 0;
        @(negedge clk); K = k; M = m; N = n; in_valid = 1;
        @(negedge clk); in_valid = 0;
        for (int c = 0; c < 6000 && !finished; c++) begin
            sa_done = 0; in_valid = 0;
            if (done) finished = 1;
            else begin
                if (sa_start) begin
                    cd = dly;
                    if (poke && !poked) begin
                        in_valid = 1; K = 0; M = 8; N = 8; poked = 1;
                    end
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin sa_done = 1; cd = -1; end
                end
                @(negedge clk);
            end
        end
        sa_done = 0; in_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; sa_done = 0; K = 0; M = 0; N = 0;
        clear_counts();
        #7;
        n_cmp++;
        if ({busy, done, err, sa_start, a_base, b_base, k_len, wb_row, C_wr_en, C_index, tile_m, tile_n} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b sa_start=%b a=%0d b=%0d idx=%0d want all 0",
                     busy, sa_start, a_base, b_base, C_index);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_job(input string name, input int k, input int m, input int n, input int dly,
                            input int want_start, input int want_wr, input int want_gap);
        bit fin;
        clear_counts();
        push_exp(k, m, n);
        drive_job(8'(k), 8'(m), 8'(n), dly, 1'b0, fin);
        @(negedge clk);
        n_cmp++;
        if (!fin) begin n_bad++; $display("FAIL %s_timeout: done never seen", name); end
        n_cmp++;
        if ({cnt_start, cnt_wr, cnt_done} !== {want_start, want_wr, 32'd1}) begin
            n_bad++;
            $display("FAIL %s_counts: got start=%0d wr=%0d done=%0d want start=%0d wr=%0d done=1",
                     name, cnt_start, cnt_wr, cnt_done, want_start, want_wr);
        end
        n_cmp++;
        if (done_cyc - last_wr_cyc !== want_gap) begin
            n_bad++;
            $display("FAIL %s_done_gap: got %0d want %0d", name, done_cyc - last_wr_cyc, want_gap);
        end
        n_cmp++;
        if ({busy, done} !== 2'b00 || exp_tile.size() + exp_wr.size() != 0) begin
            n_bad++;
            $display("FAIL %s_end: busy=%b done=%b left=%0d want busy=0 done=0 left=0",
                     name, busy, done, exp_tile.size() + exp_wr.size());
        end
    endtask

    task automatic test_reject();
        logic [7:0] dims [3][3];
        dims = '{'{8'd0, 8'd4, 8'd4}, '{8'd4, 8'd0, 8'd4}, '{8'd4, 8'd4, 8'd0}};
        for (int i = 0; i < 3; i++) begin
            clear_counts();
            @(negedge clk); K = dims[i][0]; M = dims[i][1]; N = dims[i][2]; in_valid = 1;
            @(negedge clk); in_valid = 0;
            n_cmp++;
            if ({err, busy, sa_start} !== 3'b100) begin
                n_bad++;
                $display("FAIL reject_pulse: case %0d err=%b busy=%b sa_start=%b want 1 0 0", i, err, busy, sa_start);
            end
            @(negedge clk);
            @(negedge clk);
            n_cmp++;
            if ({err, busy, cnt_err, cnt_start} !== {2'b00, 32'd1, 32'd0}) begin
                n_bad++;
                $display("FAIL reject_after: case %0d err=%b busy=%b errs=%0d starts=%0d want 0 0 1 0",
                         i, err, busy, cnt_err, cnt_start);
            end
        end
    endtask

    task automatic test_ignore_busy();
        bit fin;
        clear_counts();
        push_exp(4, 4, 4);
        drive_job(8'd4, 8'd4, 8'd4, 3, 1'b1, fin);
        @(negedge clk);
        n_cmp++;
        if ({fin, cnt_start, cnt_wr, cnt_err, k_len} !== {1'b1, 32'd1, 32'd4, 32'd0, 8'd4}) begin
            n_bad++;
            $display("FAIL ignore_busy: fin=%b start=%0d wr=%0d err=%0d k_len=%0d want 1 1 4 0 4",
                     fin, cnt_start, cnt_wr, cnt_err, k_len);
        end
    endtask

    task automatic test_sa_done_hold();
        bit early;
        bit fin;
        clear_counts();
        push_exp(4, 4, 4);
        early = 0; fin = 0;
        @(negedge clk); K = 4; M = 4; N = 4; in_valid = 1;
        @(negedge clk); in_valid = 0; sa_done = 1;
        @(negedge clk); sa_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (C_wr_en || !busy) early = 1;
        end
        n_cmp++;
        if (early) begin n_bad++; $display("FAIL sa_done_early: got writeback before sa_done in WAIT want none"); end
        sa_done = 1;
        @(negedge clk); sa_done = 0;
        n_cmp++;
        if ({C_wr_en, wb_row, C_index} !== {1'b1, 2'd0, 16'd0}) begin
            n_bad++;
            $display("FAIL sa_done_wb: got en=%b row=%0d idx=%0d want 1 0 0", C_wr_en, wb_row, C_index);
        end
        for (int c = 0; c < 20 && !fin; c++) begin
            if (done) fin = 1; else @(negedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if ({fin, cnt_wr, exp_wr.size()} !== {1'b1, 32'd4, 32'd0}) begin
            n_bad++;
            $display("FAIL sa_done_end: fin=%b wr=%0d left=%0d want 1 4 0", fin, cnt_wr, exp_wr.size());
        end
    endtask

    task automatic test_midjob_reset();
        bit hit;
        clear_counts();
        push_exp(4, 4, 4);
        hit = 0;
        @(negedge clk); K = 4; M = 4; N = 4; in_valid = 1;
        @(negedge clk); in_valid = 0;
        @(negedge clk); sa_done = 1;
        @(negedge clk); sa_done = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (C_wr_en && wb_row == 2'd2) hit = 1; else @(negedge clk);
        end
        n_cmp++;
        if (!hit) begin n_bad++; $display("FAIL midreset_reach: row 2 never seen want seen"); end
        #1 rst_n = 0;
        #1;
        n_cmp++;
        if ({busy, done, err, sa_start, a_base, b_base, k_len, wb_row, C_wr_en, C_index, tile_m, tile_n} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: busy=%b en=%b row=%0d idx=%0d k_len=%0d want all 0",
                     busy, C_wr_en, wb_row, C_index, k_len);
        end
        exp_tile.delete();
        exp_wr.delete();
        @(negedge clk); rst_n = 1;
        test_job("after_reset", 8, 6, 4, 2, 2, 6, 3);
    endtask

    task automatic test_back_to_back();
        bit fin1, fin2;
        clear_counts();
        push_exp(4, 4, 4);
        push_exp(4, 8, 4);
        drive_job(8'd4, 8'd4, 8'd4, 1, 1'b0, fin1);
        drive_job(8'd4, 8'd8, 8'd4, 1, 1'b0, fin2);
        @(negedge clk);
        n_cmp++;
        if ({fin1, fin2, cnt_start, cnt_wr, cnt_done} !== {2'b11, 32'd3, 32'd12, 32'd2}) begin
            n_bad++;
            $display("FAIL back_to_back: fin=%b%b start=%0d wr=%0d done=%0d want 11 3 12 2",
                     fin1, fin2, cnt_start, cnt_wr, cnt_done);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_job("single", 4, 4, 4, 2, 1, 4, 1);
        test_job("pad_m", 8, 6, 4, 1, 2, 6, 3);
        test_job("two_n", 4, 4, 8, 3, 2, 8, 1);
        test_job("wide", 255, 255, 5, 1, 128, 510, 2);
        test_reject();
        test_ignore_busy();
        test_sa_done_hold();
        test_midjob_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
